mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Front-end stage directly upstream of the shift-add multiplier. Converts it into a valid/ready request/response unit.
- Accepts one operand pair and drives the multiplier's operand inputs, holding them stable. Restarts the multiplier through its reset input, then watches its 2-bit state until DONE.
- Captures the 64-bit product and presents it downstream with backpressure. One operation is in flight at a time.

Parameters:
- START_CYCLES, 1: cycles mult_reset is held high to restart the multiplier (legal range 1..15).
- DONE_STATE, 2'b11: multiplier state encoding that means the product is final.
- TIMEOUT, 200: maximum WAIT cycles before aborting (legal range 1..1023).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  32  multiplicand.
- in_b  in  32  multiplier operand.
- mult_reset  out  1  drives the multiplier's reset input.
- mult_multiplicand  out  32  registered operand A to the multiplier.
- mult_multiplier  out  32  registered operand B to the multiplier.
- mult_product  in  64  product from the multiplier.
- mult_state  in  2  state from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_product  out  64  captured result.
- busy  out  1  high in any state except IDLE.
- timeout_err  out  1  sticky: an operation timed out; cleared only by reset.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, busy=0, timeout_err=0.
  - mult_reset=1, so the multiplier is held in reset while idle.
  - mult_multiplicand=0, mult_multiplier=0, out_product=0.
  - Wait counter and launch counter are 0.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - in_ready=1, mult_reset=1.
  - When in_valid&&in_ready at a rising edge: register in_a/in_b into mult_multiplicand/mult_multiplier, clear the launch counter, go to LAUNCH.
- LAUNCH:
  - in_ready=0, mult_reset=1. The launch counter increments each cycle.
  - After START_CYCLES cycles in LAUNCH, go to WAIT and clear the wait counter.
- WAIT:
  - mult_reset=0; operands stay constant. The wait counter increments each cycle.
  - If mult_state==DONE_STATE: capture mult_product into out_product at that edge, go to HOLD.
  - Else if the wait counter==TIMEOUT-1: out_product<=0, timeout_err<=1, go to HOLD.
  - DONE takes priority over timeout in the same cycle.
- HOLD:
  - out_valid=1. mult_reset=1, so the multiplier is parked.
  - out_product stays stable until out_ready. On out_valid&&out_ready go to IDLE, and out_valid=0 from the next cycle.
- No bypass between results. A new operand is accepted at the earliest one cycle after the result handshake, because IDLE lasts at least one cycle.
- Latency from the accepting edge to out_valid high: START_CYCLES + N + 1 cycles, where N is the number of WAIT cycles before DONE is sampled.
- Backpressure: out_valid may stay high indefinitely. Inputs are ignored while busy; in_valid with in_ready=0 is a no-op.
- Reset mid-operation, in any state: immediate return to the reset values. Any in-flight result is discarded and timeout_err is cleared.
- mult_multiplicand/mult_multiplier keep their last values after completion, not zeroed.
- Counters are sized for their parameter ranges: 4-bit launch counter, 10-bit wait counter. No wrap is reachable.

Optional Feature:
- Macro: MULT_SEQ_SIGNED_EN.
- When defined, operands are treated as two's complement:
  - In IDLE on accept, the registered operands are |in_a| and |in_b|.
  - A sign flag sign_q = in_a[31]^in_b[31] is stored.
  - At DONE capture, out_product = sign_q ? -mult_product : mult_product, as 64-bit two's complement.
  - 0x80000000 magnitude is 0x80000000 taken as unsigned, which is exact.
  - The timeout result is still 0.
- When undefined: operands pass through unsigned and no sign logic is instantiated.

Test Plan:
- Reset, then in_a=3, in_b=5, out_ready=1 with a behavioural multiplier model (DONE after 33 cycles) -> out_product=64'd15; out_valid rises exactly START_CYCLES+33+1 cycles after accept; timeout_err=0.
- in_a=in_b=32'hFFFFFFFF -> out_product=64'hFFFFFFFE00000001.
- Hold out_ready=0 for 20 cycles after out_valid, pulsing in_valid with in_a=7, in_b=9 meanwhile -> out_product stable at the first result; in_ready=0 throughout; the second pair is accepted only after the handshake; its result is 63.
- Model never reaches DONE, TIMEOUT=50 -> out_valid after START_CYCLES+50 cycles with out_product=0 and timeout_err=1; timeout_err stays 1 through the next good operation until reset.
- Assert reset for 1 cycle while in WAIT -> next cycle: IDLE, busy=0, out_valid=0, mult_reset=1, no result is ever emitted.
- With MULT_SEQ_SIGNED_EN: in_a=-3, in_b=7 -> mult_multiplicand=3, out_product=64'hFFFFFFFFFFFFFFEB. Then in_a=-4, in_b=-4 -> out_product=16.

Source files
------------

// File: rtl/mult_sequencer.sv
// mult_sequencer: valid/ready front end for the shift-add multiplier.
// Registers one operand pair and restarts the multiplier by holding its
// reset for START_CYCLES cycles. It then waits for DONE_STATE, or aborts
// after TIMEOUT cycles, and holds the product until downstream takes it.
// Optional macro MULT_SEQ_SIGNED_EN: two's-complement operands. The
// magnitudes are sent to the multiplier, and the captured product has its
// sign restored.
module mult_sequencer #(
  parameter int         START_CYCLES = 1,
  parameter logic [1:0] DONE_STATE   = 2'b11,
  parameter int         TIMEOUT      = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mult_reset,
  output logic [31:0] mult_multiplicand,
  output logic [31:0] mult_multiplier,
  input  logic [63:0] mult_product,
  input  logic [1:0]  mult_state,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_product,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  localparam logic [3:0] LAUNCH_LAST = 4'(START_CYCLES - 1);
  localparam logic [9:0] WAIT_LAST   = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  launch_cnt;
  logic [9:0]  wait_cnt;
  logic        accept, done, expired;
  logic [31:0] a_mag, b_mag;
  logic [63:0] product_fix;

  assign accept  = in_valid && in_ready;
  assign done    = (mult_state == DONE_STATE);
  assign expired = (wait_cnt == WAIT_LAST);

`ifdef MULT_SEQ_SIGNED_EN
  logic sign_q;
  // Magnitudes go to the unsigned multiplier. 0x80000000 maps to itself,
  // and that value is exact when read as unsigned.
  assign a_mag       = in_a[31] ? -in_a : in_a;
  assign b_mag       = in_b[31] ? -in_b : in_b;
  assign product_fix = sign_q ? -mult_product : mult_product;

  // Result sign, latched together with the operands.
  always_ff @(posedge clock) begin
    if (reset)       sign_q <= 1'b0;
    else if (accept) sign_q <= in_a[31] ^ in_b[31];
  end
`else
  assign a_mag       = in_a;
  assign b_mag       = in_b;
  assign product_fix = mult_product;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and the control outputs that are decoded from the state.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    mult_reset = 1'b1;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = S_LAUNCH;
      end
      S_LAUNCH: if (launch_cnt == LAUNCH_LAST) state_d = S_WAIT;
      S_WAIT: begin
        mult_reset = 1'b0;
        if (done || expired) state_d = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand, counter, result and sticky-error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mult_multiplicand <= '0;
      mult_multiplier   <= '0;
      out_product       <= '0;
      launch_cnt        <= '0;
      wait_cnt          <= '0;
      timeout_err       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          mult_multiplicand <= a_mag;
          mult_multiplier   <= b_mag;
          launch_cnt        <= '0;
        end
        S_LAUNCH: begin
          launch_cnt <= launch_cnt + 4'd1;
          if (launch_cnt == LAUNCH_LAST) wait_cnt <= '0;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 10'd1;
          // DONE wins over timeout when both happen in the same cycle.
          if (done) out_product <= product_fix;
          else if (expired) begin
            out_product <= '0;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer. A behavioural multiplier reaches DONE 33
// cycles after its reset is released, or never when never_done is set.
module tb_mult_sequencer;

  localparam int S   = 2;
  localparam int TMO = 50;
  localparam int LAT_OK  = S + 33 + 1;
  localparam int LAT_TMO = S + TMO;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, mult_reset, out_valid, out_ready;
  logic        busy, timeout_err;
  logic [31:0] in_a, in_b, mult_multiplicand, mult_multiplier;
  logic [63:0] mult_product, out_product;
  logic [1:0]  mult_state;

  logic        never_done = 1'b0;
  int          mcnt;
  int          errors = 0, checks = 0;

  always #5 clock = ~clock;

  mult_sequencer #(.START_CYCLES(S), .DONE_STATE(2'b11), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mult_reset(mult_reset),
    .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
    .mult_product(mult_product), .mult_state(mult_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Behavioural multiplier: counts the cycles spent out of reset.
  always_ff @(posedge clock) begin
    if (mult_reset) mcnt <= 0;
    else            mcnt <= mcnt + 1;
  end
  assign mult_state   = (!never_done && mcnt >= 33) ? 2'b11 : 2'b01;
  assign mult_product = {32'b0, mult_multiplicand} * {32'b0, mult_multiplier};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] mcand;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic accept_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 400) begin @(posedge clock); #1; n++; end
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin @(posedge clock); #1; lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("valid_drop", {63'b0, out_valid}, 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input int lat_exp, input logic terr_exp);
    int lat;
    accept_op(v.a, v.b);
    check("mcand", {32'b0, mult_multiplicand}, {32'b0, v.mcand});
    wait_result(lat);
    check("latency", 64'(lat), 64'(lat_exp));
    check("product", out_product, v.prod);
    check("timeout_err", {63'b0, timeout_err}, {63'b0, terr_exp});
    handshake();
  endtask

  initial begin
    int lat;
    logic seen;
`ifdef MULT_SEQ_SIGNED_EN
    vecs[0] = '{32'hFFFFFFFD, 32'd7,        32'd3,        64'hFFFFFFFFFFFFFFEB};
    vecs[1] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'd4,        64'd16};
    vecs[2] = '{32'h80000000, 32'd1,        32'h80000000, 64'hFFFFFFFF80000000};
    vecs[3] = '{32'd5,        32'd6,        32'd5,        64'd30};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        64'd1};
`else
    vecs[0] = '{32'd3,        32'd5,        32'd3,        64'd15};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{32'd0,        32'd12345,    32'd0,        64'd0};
    vecs[3] = '{32'd1,        32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF};
    vecs[4] = '{32'h80000000, 32'd2,        32'h80000000, 64'h0000000100000000};
`endif
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",    {63'b0, in_ready},    64'd1);
    check("rst_out_valid",   {63'b0, out_valid},   64'd0);
    check("rst_busy",        {63'b0, busy},        64'd0);
    check("rst_timeout_err", {63'b0, timeout_err}, 64'd0);
    check("rst_mult_reset",  {63'b0, mult_reset},  64'd1);
    check("rst_mcand",       {32'b0, mult_multiplicand}, 64'd0);
    check("rst_mplier",      {32'b0, mult_multiplier},   64'd0);
    check("rst_product",     out_product,          64'd0);
    reset = 1'b0;

    // Table of directed vectors.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], LAT_OK, 1'b0);

    // Backpressure: the result is held while a second pair is offered.
    accept_op(32'd3, 32'd5);
    wait_result(lat);
    check("bp_latency", 64'(lat), 64'(LAT_OK));
    in_a = 32'd7; in_b = 32'd9;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      @(posedge clock); #1;
      if (out_product !== 64'd15 || in_ready !== 1'b0 || out_valid !== 1'b1) seen = 1'b1;
    end
    check("bp_stable", {63'b0, seen}, 64'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("bp_valid_drop", {63'b0, out_valid}, 64'd0);
    check("bp_idle_ready", {63'b0, in_ready},  64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("bp_second_busy", {63'b0, busy}, 64'd1);
    check("bp_second_mcand", {32'b0, mult_multiplicand}, 64'd7);
    wait_result(lat);
    check("bp_second_latency", 64'(lat), 64'(LAT_OK));
    check("bp_second_product", out_product, 64'd63);
    handshake();

    // Timeout, then a good op with timeout_err still sticky.
    never_done = 1'b1;
    accept_op(32'd4, 32'd4);
    wait_result(lat);
    check("tmo_latency", 64'(lat), 64'(LAT_TMO));
    check("tmo_product", out_product, 64'd0);
    check("tmo_err", {63'b0, timeout_err}, 64'd1);
    handshake();
    never_done = 1'b0;
    run_vec(vecs[3], LAT_OK, 1'b1);

    // Reset while in WAIT: the in-flight result is dropped.
    accept_op(32'd6, 32'd6);
    repeat (S + 5) @(posedge clock);
    #1;
    check("mid_mult_reset_low", {63'b0, mult_reset}, 64'd0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_busy",        {63'b0, busy},        64'd0);
    check("mid_out_valid",   {63'b0, out_valid},   64'd0);
    check("mid_mult_reset",  {63'b0, mult_reset},  64'd1);
    check("mid_in_ready",    {63'b0, in_ready},    64'd1);
    check("mid_timeout_err", {63'b0, timeout_err}, 64'd0);
    check("mid_mcand",       {32'b0, mult_multiplicand}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_result", {63'b0, seen}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
